// File: rtl/unsigned_down_syncload_timer_pkg.sv
// rtl/unsigned_down_syncload_timer_pkg.sv - shared state encoding and width default for the counter family
package unsigned_down_syncload_timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } timer_state_e;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/unsigned_down_syncload_timer.sv
// rtl/unsigned_down_syncload_timer.sv - down-counting timer with synchronous load, terminal-count pulse and optional auto-reload
module unsigned_down_syncload_timer
   import unsigned_down_syncload_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             SLOAD,
   input  logic [WIDTH-1:0] D,
   input  logic             CE,
   input  logic             RELOAD,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             BUSY
);

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   timer_state_e     state_q;
   timer_state_e     state_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;
   logic             tc_q;
   logic             tc_d;
   logic             terminal;

   // Terminal is detected on Q==1 so TC lands in the same cycle Q shows 0 or the reload value.
   assign terminal = (count_q == CNT_ONE);

   always_ff @(posedge C) begin
      if (CLR) begin
         state_q  <= ST_IDLE;
         count_q  <= CNT_ZERO;
         reload_q <= CNT_ZERO;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (SLOAD) begin
         count_d  = D;
         reload_d = D;
         state_d  = (D != CNT_ZERO) ? ST_RUN : ST_IDLE;
      end else if ((state_q == ST_RUN) && CE) begin
         if (terminal) begin
            tc_d = 1'b1;
            if (RELOAD) begin
               count_d = reload_q;
            end else begin
               count_d = CNT_ZERO;
               state_d = ST_IDLE;
            end
         end else begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge C) begin
      if (CLR) begin
         tc_q <= 1'b0;
      end else begin
         tc_q <= tc_d;
      end
   end

   assign Q    = count_q;
   assign TC   = tc_q;
   assign BUSY = (state_q == ST_RUN);

endmodule

// File: tb/tb_unsigned_down_syncload_timer.sv
// tb/tb_unsigned_down_syncload_timer.sv - directed self-checking bench for the down timer
module tb_unsigned_down_syncload_timer;

   localparam int WIDTH = 4;

   logic             C;
   logic             CLR;
   logic             SLOAD;
   logic [WIDTH-1:0] D;
   logic             CE;
   logic             RELOAD;
   logic [WIDTH-1:0] Q;
   logic             TC;
   logic             BUSY;

   int tests_run;
   int tests_failed;
   int tc_count;

   unsigned_down_syncload_timer #(.WIDTH(WIDTH)) dut (
      .C(C),
      .CLR(CLR),
      .SLOAD(SLOAD),
      .D(D),
      .CE(CE),
      .RELOAD(RELOAD),
      .Q(Q),
      .TC(TC),
      .BUSY(BUSY)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic expect_out(input string tag, input int q, input int tc, input int busy);
      check({tag, ".Q"}, int'(Q), q);
      check({tag, ".TC"}, int'(TC), tc);
      check({tag, ".BUSY"}, int'(BUSY), busy);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      CLR    = 1'b1;
      SLOAD  = 1'b0;
      D      = '0;
      CE     = 1'b0;
      RELOAD = 1'b0;

      for (int i = 0; i < 2; i++) begin
         SLOAD = 1'($urandom_range(0, 1));
         D     = WIDTH'($urandom_range(0, 15));
         CE    = 1'($urandom_range(0, 1));
         tick();
         expect_out("reset", 0, 0, 0);
      end
      CLR = 1'b0; SLOAD = 1'b0; CE = 1'b0;
      tick();
      expect_out("post_reset", 0, 0, 0);

      // One-shot from 3
      SLOAD = 1'b1; D = 4'd3; RELOAD = 1'b0; CE = 1'b1;
      tick();
      expect_out("os_load", 3, 0, 1);
      SLOAD = 1'b0;
      tick(); expect_out("os_2", 2, 0, 1);
      tick(); expect_out("os_1", 1, 0, 1);
      tick(); expect_out("os_0", 0, 1, 0);
      tick(); expect_out("os_hold0", 0, 0, 0);
      tick(); expect_out("os_hold1", 0, 0, 0);

      // Periodic from 4
      SLOAD = 1'b1; D = 4'd4; RELOAD = 1'b1; CE = 1'b1;
      tick();
      expect_out("per_load", 4, 0, 1);
      SLOAD = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         expect_out($sformatf("per_%0d", i), (i % 4 == 0) ? 4 : 4 - (i % 4), (i % 4 == 0) ? 1 : 0, 1);
      end

      // CE gating
      SLOAD = 1'b1; D = 4'd2; RELOAD = 1'b0; CE = 1'b0;
      tick(); expect_out("gate_load", 2, 0, 1);
      SLOAD = 1'b0; CE = 1'b1;
      tick(); expect_out("gate_1", 1, 0, 1);
      CE = 1'b0;
      tick(); expect_out("gate_hold", 1, 0, 1);
      CE = 1'b1;
      tick(); expect_out("gate_0", 0, 1, 0);
      tick(); expect_out("no_underflow", 0, 0, 0);

      // Zero load stays idle, never flags terminal
      SLOAD = 1'b1; D = 4'd0;
      tick(); expect_out("zero_load", 0, 0, 0);
      SLOAD = 1'b0;
      tick(); expect_out("zero_after", 0, 0, 0);

      // Full range with reload
      SLOAD = 1'b1; D = 4'd15; RELOAD = 1'b1; CE = 1'b1;
      tick(); expect_out("max_load", 15, 0, 1);
      SLOAD = 1'b0;
      tc_count = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (TC) tc_count++;
         if (i == 14) expect_out("max_at1", 1, 0, 1);
      end
      expect_out("max_wrap", 15, 1, 1);
      check("max_tc_count", tc_count, 1);

      // Reload value 1 gives TC every enabled cycle
      SLOAD = 1'b1; D = 4'd1; RELOAD = 1'b1; CE = 1'b1;
      tick(); expect_out("r1_load", 1, 0, 1);
      SLOAD = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("r1_%0d", i), 1, 1, 1);
      end

      // SLOAD wins on the terminal edge
      SLOAD = 1'b1; D = 4'd2; RELOAD = 1'b0; CE = 1'b1;
      tick(); expect_out("col_load", 2, 0, 1);
      SLOAD = 1'b0;
      tick(); expect_out("col_1", 1, 0, 1);
      SLOAD = 1'b1; D = 4'd5;
      tick(); expect_out("col_sload", 5, 0, 1);
      SLOAD = 1'b0;
      tick(); expect_out("col_after", 4, 0, 1);

      // CLR wins on the terminal edge
      SLOAD = 1'b1; D = 4'd1; RELOAD = 1'b1; CE = 1'b0;
      tick(); expect_out("clr_load", 1, 0, 1);
      SLOAD = 1'b0; CE = 1'b1; CLR = 1'b1;
      tick(); expect_out("clr_term", 0, 0, 0);
      CLR = 1'b0;
      tick(); expect_out("clr_after", 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
